alarma_fsm: RTL and testbench

Sequential vehicle-alarm controller. It consumes the same arm switch, intrusion sensors and panic input as the combinational `alarma`/`alarma2` evaluators and produces the horn drive. It adds exit and entry delays, timed alarm bursts and a pulsed horn pattern. It sits between the debounced sensor inputs and the horn driver, and replaces the combinational `Bocina` path in the top level.

---
 rtl/alarma_pkg.sv | 19 +
 rtl/alarma_timer.sv | 29 ++
 rtl/alarma_fsm.sv | 127 ++++++++++++
 tb/tb_alarma_fsm.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarma_pkg.sv
// Shared definitions for the sequential vehicle alarm: state codes and Estado width.
package alarma_pkg;

  localparam int EST_W = 3;

  typedef enum logic [EST_W-1:0] {
    DESARMADA = 3'd0,
    SALIDA    = 3'd1,
    ARMADA    = 3'd2,
    ENTRADA   = 3'd3,
    DISPARO   = 3'd4,
    PANICO    = 3'd5
  } estado_e;

  function automatic logic is_armada(estado_e s);
    return (s == ARMADA) || (s == ENTRADA) || (s == DISPARO);
  endfunction

endpackage

// File: rtl/alarma_timer.sv
// Loadable down-counter that holds at zero; used as state timer and as beep counter.
module alarma_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] value_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign value_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/alarma_fsm.sv
// Vehicle alarm controller: exit/entry delays, timed bursts and pulsed horn, all outputs registered.
module alarma_fsm
  import alarma_pkg::*;
#(
  parameter int EXIT_CYC  = 16,
  parameter int ENTRY_CYC = 8,
  parameter int ALARM_CYC = 64,
  parameter int BEEP_HALF = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             P,
  input  logic             Co,
  input  logic             Ca,
  input  logic             G,
  input  logic             V,
  input  logic             Pa,
  output logic             Bocina,
  output logic             Armada,
  output logic [EST_W-1:0] Estado
);

  localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_CYC - 1);
  localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_CYC - 1);
  localparam logic [CNT_W-1:0] ALARM_LD = CNT_W'(ALARM_CYC - 1);
  localparam logic [CNT_W-1:0] BEEP_LD  = CNT_W'(BEEP_HALF - 1);

  estado_e          state_q, state_d;
  logic             bocina_q, bocina_d;
  logic             armada_q, armada_d;
  logic             instant;
  logic             tmr_load, tmr_zero;
  logic             beep_load, beep_zero;
  logic [CNT_W-1:0] tmr_ld_val, tmr_value, beep_value;

  assign instant = Co | Ca | G | V;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d = state_q;
    if (Pa) begin
      state_d = PANICO;
    end else begin
      case (state_q)
        DESARMADA: if (A) state_d = SALIDA;
        SALIDA:    if (!A) state_d = DESARMADA;
                   else if (tmr_zero) state_d = ARMADA;
        ARMADA:    if (!A) state_d = DESARMADA;
                   else if (instant) state_d = DISPARO;
                   else if (P) state_d = ENTRADA;
        ENTRADA:   if (!A) state_d = DESARMADA;
                   else if (instant || tmr_zero) state_d = DISPARO;
        DISPARO:   if (!A) state_d = DESARMADA;
                   else if (tmr_zero) state_d = ARMADA;
        PANICO:    if (tmr_zero) state_d = A ? ARMADA : DESARMADA;
        default:   state_d = DESARMADA;
      endcase
    end
  end

  // A held panic button reloads the burst even though the state does not change.
  assign tmr_load = (state_d != state_q) || Pa;

  always_comb begin
    tmr_ld_val = '0;
    case (state_d)
      SALIDA:           tmr_ld_val = EXIT_LD;
      ENTRADA:          tmr_ld_val = ENTRY_LD;
      DISPARO, PANICO:  tmr_ld_val = ALARM_LD;
      default:          tmr_ld_val = '0;
    endcase
  end

  assign beep_load = (state_d == DISPARO) && ((state_q != DISPARO) || beep_zero);

  always_comb begin
    bocina_d = 1'b0;
    if (state_d == PANICO) begin
      bocina_d = 1'b1;
    end else if (state_d == DISPARO) begin
      if (state_q != DISPARO) bocina_d = 1'b1;
      else                    bocina_d = beep_zero ? ~bocina_q : bocina_q;
    end
    armada_d = is_armada(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DESARMADA;
      bocina_q <= 1'b0;
      armada_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bocina_q <= bocina_d;
      armada_q <= armada_d;
    end
  end

  alarma_timer #(.CNT_W(CNT_W)) u_state_tmr (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_ld_val),
    .value_o   (tmr_value),
    .zero_o    (tmr_zero)
  );

  alarma_timer #(.CNT_W(CNT_W)) u_beep_tmr (
    .clk       (clk),
    .rst       (rst),
    .load_i    (beep_load),
    .load_val_i(BEEP_LD),
    .value_o   (beep_value),
    .zero_o    (beep_zero)
  );

  // Raw counter values are not needed by the control logic; fold them into a sink.
  logic unused_value;
  assign unused_value = ^{tmr_value, beep_value};

  assign Estado = state_q;
  assign Bocina = bocina_q;
  assign Armada = armada_q;

endmodule

// File: tb/tb_alarma_fsm.sv
// Self-checking bench for alarma_fsm: vector table, scenario sequences and random run against an age-based model.
`timescale 1ns/1ps
module tb_alarma_fsm;
  import alarma_pkg::*;

  localparam int EXIT_CYC  = 16;
  localparam int ENTRY_CYC = 8;
  localparam int ALARM_CYC = 64;
  localparam int BEEP_HALF = 4;
  localparam int CNT_W     = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             A = 1'b0, P = 1'b0, Co = 1'b0, Ca = 1'b0, G = 1'b0, V = 1'b0, Pa = 1'b0;
  logic             Bocina, Armada;
  logic [EST_W-1:0] Estado;

  int checks   = 0;
  int failures = 0;

  // Reference model: state code plus cycles spent since the last (re)entry.
  int m_st  = 0;
  int m_age = 0;

  always #5 clk = ~clk;

  alarma_fsm #(
    .EXIT_CYC (EXIT_CYC),
    .ENTRY_CYC(ENTRY_CYC),
    .ALARM_CYC(ALARM_CYC),
    .BEEP_HALF(BEEP_HALF),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .P     (P),
    .Co    (Co),
    .Ca    (Ca),
    .G     (G),
    .V     (V),
    .Pa    (Pa),
    .Bocina(Bocina),
    .Armada(Armada),
    .Estado(Estado)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dur(input int s);
    case (s)
      1:       return EXIT_CYC;
      3:       return ENTRY_CYC;
      4, 5:    return ALARM_CYC;
      default: return 0;
    endcase
  endfunction

  function automatic int m_horn();
    if (m_st == 5) return 1;
    if (m_st == 4) return (((m_age / BEEP_HALF) % 2) == 0) ? 1 : 0;
    return 0;
  endfunction

  function automatic int m_arm();
    return (m_st == 2 || m_st == 3 || m_st == 4) ? 1 : 0;
  endfunction

  task automatic model_step(input logic r, input logic a, input logic p, input logic pa,
                            input logic [3:0] z);
    int ns;
    bit expire;
    if (r) begin
      m_st  = 0;
      m_age = 0;
      return;
    end
    expire = (dur(m_st) > 0) && (m_age == dur(m_st) - 1);
    ns = m_st;
    if (pa) ns = 5;
    else begin
      case (m_st)
        0: if (a) ns = 1;
        1: if (!a) ns = 0; else if (expire) ns = 2;
        2: if (!a) ns = 0; else if (z != 4'b0) ns = 4; else if (p) ns = 3;
        3: if (!a) ns = 0; else if (z != 4'b0 || expire) ns = 4;
        4: if (!a) ns = 0; else if (expire) ns = 2;
        5: if (expire) ns = a ? 2 : 0;
        default: ns = 0;
      endcase
    end
    if (ns != m_st || pa) m_age = 0;
    else                  m_age++;
    m_st = ns;
  endtask

  // One clock: drive inputs, advance model on the edge, sample #1 later.
  task automatic step(input logic r, input logic a, input logic p, input logic [3:0] z,
                      input logic pa);
    rst = r; A = a; P = p; {Co, Ca, G, V} = z; Pa = pa;
    @(posedge clk);
    model_step(r, a, p, pa, z);
    #1;
    check("model_estado", int'(Estado), m_st);
    check("model_armada", int'(Armada), m_arm());
    check("model_bocina", int'(Bocina), m_horn());
  endtask

  task automatic arm_up();
    for (int i = 0; i < EXIT_CYC + 1; i++) step(1'b0, 1'b1, 1'b0, 4'b0, 1'b0);
    check("arm_up_estado", int'(Estado), int'(ARMADA));
  endtask

  typedef struct {
    logic       r, a, p, pa;
    logic [3:0] z;
    int         est, arm, horn;
  } vec_t;

  function automatic vec_t mkv(input logic r, input logic a, input logic p, input logic pa,
                               input logic [3:0] z, input int est, input int arm, input int horn);
    vec_t v;
    v.r = r; v.a = a; v.p = p; v.pa = pa; v.z = z;
    v.est = est; v.arm = arm; v.horn = horn;
    return v;
  endfunction

  vec_t vecs[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, errs, horn_seen;
    logic a_r;

    vecs[0] = mkv(1, 0, 0, 1, 4'b0000, 0, 0, 0);  // reset dominates panic
    vecs[1] = mkv(0, 0, 0, 1, 4'b0000, 5, 0, 1);  // panic with A=0
    vecs[2] = mkv(1, 0, 0, 0, 4'b0000, 0, 0, 0);  // reset silences burst
    vecs[3] = mkv(0, 1, 0, 0, 4'b0000, 1, 0, 0);  // arm -> exit delay
    vecs[4] = mkv(0, 1, 0, 0, 4'b0001, 1, 0, 0);  // window ignored in exit delay
    vecs[5] = mkv(0, 0, 0, 0, 4'b0000, 0, 0, 0);  // disarm during exit
    vecs[6] = mkv(0, 1, 0, 1, 4'b0000, 5, 0, 1);
    vecs[7] = mkv(0, 1, 0, 0, 4'b0000, 5, 0, 1);
    vecs[8] = mkv(0, 0, 0, 0, 4'b0000, 5, 0, 1);  // A=0 does not cancel panic
    vecs[9] = mkv(1, 0, 0, 0, 4'b0000, 0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].r, vecs[i].a, vecs[i].p, vecs[i].z, vecs[i].pa);
      check($sformatf("vec%0d_estado", i), int'(Estado), vecs[i].est);
      check($sformatf("vec%0d_armada", i), int'(Armada), vecs[i].arm);
      check($sformatf("vec%0d_bocina", i), int'(Bocina), vecs[i].horn);
    end

    // Arm and exit delay, with a window pulse that must be ignored.
    step(0, 1, 0, 4'b0, 0);
    n = (Estado == SALIDA) ? 1 : 0;
    for (int i = 0; i < 40 && Estado == SALIDA; i++) begin
      step(0, 1, 0, (i == 5) ? 4'b0001 : 4'b0000, 0);
      if (Estado == SALIDA) n++;
    end
    check("exit_len", n, EXIT_CYC);
    check("exit_estado", int'(Estado), int'(ARMADA));
    check("exit_armada", int'(Armada), 1);
    check("exit_bocina", int'(Bocina), 0);

    // Door entry, disarmed in time.
    step(0, 1, 1, 4'b0, 0);
    check("door_entry", int'(Estado), int'(ENTRADA));
    horn_seen = int'(Bocina);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 4'b0, 0);
      horn_seen |= int'(Bocina);
    end
    check("door_hold", int'(Estado), int'(ENTRADA));
    step(0, 0, 0, 4'b0, 0);
    check("door_disarm", int'(Estado), int'(DESARMADA));
    check("door_quiet", horn_seen | int'(Bocina), 0);

    // Door entry timeout and horn pattern.
    arm_up();
    step(0, 1, 1, 4'b0, 0);
    n = (Estado == ENTRADA) ? 1 : 0;
    for (int i = 0; i < 20 && Estado == ENTRADA; i++) begin
      step(0, 1, 0, 4'b0, 0);
      if (Estado == ENTRADA) n++;
    end
    check("entry_len", n, ENTRY_CYC);
    check("entry_timeout", int'(Estado), int'(DISPARO));
    n = 0; errs = 0;
    for (int i = 0; i < 100 && Estado == DISPARO; i++) begin
      if (int'(Bocina) != ((((i / BEEP_HALF) % 2) == 0) ? 1 : 0)) errs++;
      n++;
      step(0, 1, 0, 4'b0, 0);
    end
    check("burst_len", n, ALARM_CYC);
    check("burst_pattern_errs", errs, 0);
    check("burst_rearm", int'(Estado), int'(ARMADA));

    // Instant zone walk; each trip restarts the pattern high.
    for (int zi = 0; zi < 4; zi++) begin
      step(0, 1, 0, 4'b1000 >> zi, 0);
      check($sformatf("walk%0d_estado", zi), int'(Estado), int'(DISPARO));
      check($sformatf("walk%0d_bocina", zi), int'(Bocina), 1);
      for (int i = 0; i < 9; i++) step(0, 1, 0, 4'b0, 0);
      for (int i = 0; i < 100 && Estado != ARMADA; i++) step(0, 1, 0, 4'b0, 0);
      check($sformatf("walk%0d_rearm", zi), int'(Estado), int'(ARMADA));
    end

    // Sensor held through expiry: one ARMADA cycle then DISPARO again.
    for (int i = 0; i < ALARM_CYC + 2; i++) begin
      step(0, 1, 0, 4'b0010, 0);
      if (i == ALARM_CYC)     check("held_rearm", int'(Estado), int'(ARMADA));
      if (i == ALARM_CYC + 1) begin
        check("held_retrip", int'(Estado), int'(DISPARO));
        check("held_retrip_bocina", int'(Bocina), 1);
      end
    end
    step(0, 0, 0, 4'b0010, 0);
    check("disarm_disparo", int'(Estado), int'(DESARMADA));

    // Simultaneous events.
    arm_up();
    step(0, 0, 0, 4'b1000, 0);
    check("disarm_beats_sensor", int'(Estado), int'(DESARMADA));
    arm_up();
    step(0, 1, 1, 4'b0100, 0);
    check("zone_beats_door", int'(Estado), int'(DISPARO));

    // Reset mid-alarm.
    step(0, 1, 0, 4'b0, 0);
    step(0, 1, 0, 4'b0, 0);
    step(1, 1, 0, 4'b0, 0);
    check("rst_mid_estado", int'(Estado), 0);
    check("rst_mid_bocina", int'(Bocina), 0);
    check("rst_mid_armada", int'(Armada), 0);

    // Panic held 3 cycles, disarmed then armed.
    for (int rep = 0; rep < 2; rep++) begin
      a_r = (rep == 1);
      n = 0; errs = 0;
      for (int i = 0; i < 3; i++) begin
        step(0, a_r, 0, 4'b0, 1);
        if (Estado == PANICO) begin n++; if (Bocina != 1'b1) errs++; end
      end
      for (int i = 0; i < 200 && Estado == PANICO; i++) begin
        step(0, a_r, 0, 4'b0, 0);
        if (Estado == PANICO) begin n++; if (Bocina != 1'b1) errs++; end
      end
      check($sformatf("panic%0d_len", rep), n, ALARM_CYC + 2);
      check($sformatf("panic%0d_horn_errs", rep), errs, 0);
      check($sformatf("panic%0d_exit", rep), int'(Estado), a_r ? int'(ARMADA) : int'(DESARMADA));
      step(1, 0, 0, 4'b0, 0);
    end

    // Randomized run against the model.
    a_r = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] z;
      if ($urandom_range(0, 49) == 0) a_r = ~a_r;
      for (int b = 0; b < 4; b++) z[b] = ($urandom_range(0, 39) == 0);
      step($urandom_range(0, 149) == 0, a_r, $urandom_range(0, 19) == 0, z,
           $urandom_range(0, 79) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
